// File: rtl/div_issue_arbiter.sv
// div_issue_arbiter
// Shares one iterative divider among NUM_RS reservation stations. Only one
// divide is in flight at a time. Requesters are served round-robin. The
// quotient is held until the writeback unit accepts it with canGo_i.
//
// Ports
//   clk_i, reset_i        clock; synchronous active-high reset
//   readyRS_i             per-RS "ready divide op" request
//   rsVal1_i / rsVal2_i   packed dividends / divisors, RS[i] at [64*i +: 64]
//   rsCommands_i          packed 10-bit commands, RS[i] at [10*i +: 10]
//   rsTag_i               packed ROB tags, RS[i] at [ROBsizeLog*i +: ROBsizeLog]
//   stallRS_o             0 for the RS granted this cycle, 1 otherwise
//   divValidIn_o          one-cycle start pulse to the divider
//   divDividend_o/Divisor operands of the granted RS
//   divValidOut_i         divider result pulse
//   divQuotient_i         divider result
//   canGo_i               writeback accepts the held result
//   valid_o               result held and valid
//   executeVal_o          captured quotient
//   executeCommands_o     command of the op in flight
//   executeTag_o          ROB tag of the op in flight
//   executeSrc_o          index of the issuing RS
//   executeFlags_o        bit0 = divide-by-zero bypass taken, others 0
//
// Optional feature: define DIV_ZERO_BYPASS_EN to complete zero-divisor ops
// locally (all-ones result, flag bit0 set) without starting the divider.
//
// State table
//   S_IDLE | waiting for a ready RS; grants combinationally in this cycle
//   S_BUSY | divide in flight; waiting for divValidOut_i
//   S_DONE | result held on the execute outputs until canGo_i

module div_issue_arbiter #(
    parameter int NUM_RS     = 2,
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RS_ID_W    = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_RS-1:0]            readyRS_i,
    input  logic [64*NUM_RS-1:0]         rsVal1_i,
    input  logic [64*NUM_RS-1:0]         rsVal2_i,
    input  logic [10*NUM_RS-1:0]         rsCommands_i,
    input  logic [ROBsizeLog*NUM_RS-1:0] rsTag_i,
    output logic [NUM_RS-1:0]            stallRS_o,
    output logic                         divValidIn_o,
    output logic [63:0]                  divDividend_o,
    output logic [63:0]                  divDivisor_o,
    input  logic                         divValidOut_i,
    input  logic [63:0]                  divQuotient_i,
    input  logic                         canGo_i,
    output logic                         valid_o,
    output logic [63:0]                  executeVal_o,
    output logic [9:0]                   executeCommands_o,
    output logic [ROBsizeLog-1:0]        executeTag_o,
    output logic [RS_ID_W-1:0]           executeSrc_o,
    output logic [3:0]                   executeFlags_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [RS_ID_W-1:0] rr_ptr;

    logic               grant_found;
    int                 grant_pos;
    logic               grant_valid;
    logic [63:0]        grant_dividend;
    logic [63:0]        grant_divisor;
    logic               div_zero;

    // First ready RS strictly after rr_ptr, wrapping modulo NUM_RS. Starting
    // at rr_ptr+1 means the last winner gets the lowest priority next time.
    always_comb begin
        grant_found = 1'b0;
        grant_pos   = 0;
        for (int k = 1; k <= NUM_RS; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_RS;
            if (!grant_found && readyRS_i[idx]) begin
                grant_found = 1'b1;
                grant_pos   = idx;
            end
        end
    end

    // Reset is folded in so no RS is popped while the block is being reset.
    assign grant_valid    = grant_found && (state == S_IDLE) && !reset_i;
    assign grant_dividend = rsVal1_i[64*grant_pos +: 64];
    assign grant_divisor  = rsVal2_i[64*grant_pos +: 64];

`ifdef DIV_ZERO_BYPASS_EN
    assign div_zero = (grant_divisor == 64'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        stallRS_o = '1;
        for (int i = 0; i < NUM_RS; i++) begin
            if (grant_valid && (grant_pos == i)) begin
                stallRS_o[i] = 1'b0;
            end
        end
    end

    assign divValidIn_o  = grant_valid && !div_zero;
    assign divDividend_o = grant_dividend;
    assign divDivisor_o  = grant_divisor;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state             <= S_IDLE;
            rr_ptr            <= RS_ID_W'(NUM_RS - 1);
            valid_o           <= 1'b0;
            executeVal_o      <= '0;
            executeCommands_o <= '0;
            executeTag_o      <= '0;
            executeSrc_o      <= '0;
            executeFlags_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        rr_ptr            <= RS_ID_W'(grant_pos);
                        executeCommands_o <= rsCommands_i[10*grant_pos +: 10];
                        executeTag_o      <= rsTag_i[ROBsizeLog*grant_pos +: ROBsizeLog];
                        executeSrc_o      <= RS_ID_W'(grant_pos);
                        executeFlags_o    <= {3'b000, div_zero};
                        if (div_zero) begin
                            // Divider is skipped; result is ready next cycle.
                            executeVal_o <= '1;
                            valid_o      <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (divValidOut_i) begin
                        executeVal_o <= divQuotient_i;
                        valid_o      <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (canGo_i) begin
                        valid_o <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
